// File: rtl/rtlinf_pkg.sv
// Shared definitions for the lane MAC: default widths and the controller state encoding.
package rtlinf_pkg;

    localparam int DEF_GROUP_SIZE             = 4;
    localparam int DEF_DATA_WIDTH             = 8;
    localparam int DEF_ACC_WIDTH              = 32;
    localparam int DEF_LOG_MAX_ITERS          = 16;
    localparam int DEF_LOG_MAX_READS_PER_ITER = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_W = 2'd1,
        ST_ACC    = 2'd2,
        ST_FLUSH  = 2'd3
    } lane_state_t;

endpackage

// File: rtl/mac_element.sv
// One signed multiply feeding one accumulator register.
// Define LANE_MAC_SATURATE_EN to clamp each addition instead of wrapping.
module mac_element
    import rtlinf_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  load,
    input  logic                  add,
    input  logic [DATA_WIDTH-1:0] act,
    input  logic [DATA_WIDTH-1:0] weight,
    output logic [ACC_WIDTH-1:0]  acc
);

    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0]        prod;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] acc_s;
    logic signed [ACC_WIDTH-1:0] sum;
    logic        [ACC_WIDTH-1:0] acc_q;

    assign prod     = PW'($signed(act)) * PW'($signed(weight));
    assign prod_ext = ACC_WIDTH'(prod);
    assign acc_s    = $signed(acc_q);

`ifdef LANE_MAC_SATURATE_EN
    logic signed [ACC_WIDTH:0] wide;

    assign wide = (ACC_WIDTH + 1)'(acc_s) + (ACC_WIDTH + 1)'(prod_ext);

    // The two top bits of the widened sum disagree exactly when the addition overflowed.
    always_comb begin
        sum = $signed(wide[ACC_WIDTH-1:0]);
        if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]) begin
            if (wide[ACC_WIDTH]) begin
                sum = $signed({1'b1, {(ACC_WIDTH - 1){1'b0}}});
            end else begin
                sum = $signed({1'b0, {(ACC_WIDTH - 1){1'b1}}});
            end
        end
    end
`else
    assign sum = acc_s + prod_ext;
`endif

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc_q <= '0;
        end else if (load) begin
            acc_q <= prod_ext;
        end else if (add) begin
            acc_q <= sum;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/lane_mac.sv
// Lane MAC controller: iteration/read counters, handshakes and error flag around GROUP_SIZE mac_elements.
// Optional build macro LANE_MAC_SATURATE_EN selects saturating accumulation in the elements.
module lane_mac
    import rtlinf_pkg::*;
#(
    parameter int GROUP_SIZE             = DEF_GROUP_SIZE,
    parameter int DATA_WIDTH             = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH              = DEF_ACC_WIDTH,
    parameter int LOG_MAX_ITERS          = DEF_LOG_MAX_ITERS,
    parameter int LOG_MAX_READS_PER_ITER = DEF_LOG_MAX_READS_PER_ITER
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              configure,
    input  logic [LOG_MAX_ITERS-1:0]          num_iters,
    input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
    input  logic [GROUP_SIZE*DATA_WIDTH-1:0]  act_data_in,
    input  logic                              act_valid_in,
    output logic                              act_avail_out,
    input  logic [DATA_WIDTH-1:0]             weight_in,
    input  logic                              weight_valid_in,
    output logic                              weight_avail_out,
    output logic [GROUP_SIZE*ACC_WIDTH-1:0]   data_out,
    output logic                              valid_out,
    input  logic                              avail_in,
    output logic                              busy_out,
    output logic                              err_out
);

    localparam logic [LOG_MAX_ITERS-1:0]          ONE_I = LOG_MAX_ITERS'(1);
    localparam logic [LOG_MAX_READS_PER_ITER-1:0] ONE_R = LOG_MAX_READS_PER_ITER'(1);

    lane_state_t                       state;
    lane_state_t                       state_nxt;
    logic [LOG_MAX_ITERS-1:0]          iters_left;
    logic [LOG_MAX_READS_PER_ITER-1:0] reads_cfg;
    logic [LOG_MAX_READS_PER_ITER-1:0] read_cnt;
    logic [DATA_WIDTH-1:0]             w_q;
    logic [DATA_WIDTH-1:0]             w_sel;
    logic                              err;

    logic cfg_ok;
    logic accept_first;
    logic accept_more;
    logic accept;
    logic last_read;
    logic last_iter;
    logic handoff;
    logic proto_err;

    // Handshake: a transfer moves on a clock edge where the producer's valid and this block's
    // avail are both high; valid raised while avail is low is a protocol error and is dropped.
    // The result side mirrors this: valid_out is only raised while avail_in is high.
    assign cfg_ok = configure && (num_iters != '0) && (num_reads_per_iter != '0);

    assign act_avail_out    = ((state == ST_WAIT_W) || (state == ST_ACC)) && !configure;
    assign weight_avail_out = (state == ST_WAIT_W) && !configure;

    assign accept_first = (state == ST_WAIT_W) && !configure && act_valid_in && weight_valid_in;
    assign accept_more  = (state == ST_ACC) && !configure && act_valid_in && !weight_valid_in;
    assign accept       = accept_first || accept_more;

    assign last_read = (read_cnt == (reads_cfg - ONE_R));
    assign last_iter = (iters_left == ONE_I);

    assign handoff   = (state == ST_FLUSH) && avail_in && !configure;
    assign valid_out = handoff;

    assign proto_err = !configure && (
                           ((state == ST_WAIT_W) && act_valid_in && !weight_valid_in) ||
                           ((state == ST_ACC) && weight_valid_in) ||
                           (act_valid_in && !act_avail_out) ||
                           (weight_valid_in && !weight_avail_out));

    // The first read of an iteration multiplies by the incoming weight, later reads by the latched one.
    assign w_sel = accept_first ? weight_in : w_q;

    always_comb begin
        state_nxt = state;
        if (configure) begin
            state_nxt = cfg_ok ? ST_WAIT_W : ST_IDLE;
        end else begin
            case (state)
                ST_WAIT_W: begin
                    if (accept_first) begin
                        state_nxt = last_read ? ST_FLUSH : ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (accept_more && last_read) begin
                        state_nxt = ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (handoff) begin
                        state_nxt = last_iter ? ST_IDLE : ST_WAIT_W;
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            iters_left <= '0;
            reads_cfg  <= '0;
            read_cnt   <= '0;
            w_q        <= '0;
            err        <= 1'b0;
        end else begin
            state <= state_nxt;
            if (configure) begin
                err      <= !cfg_ok;
                read_cnt <= '0;
                if (cfg_ok) begin
                    iters_left <= num_iters;
                    reads_cfg  <= num_reads_per_iter;
                end
            end else begin
                if (proto_err) begin
                    err <= 1'b1;
                end
                if (accept_first) begin
                    w_q <= weight_in;
                end
                if (accept) begin
                    read_cnt <= last_read ? '0 : read_cnt + ONE_R;
                end
                if (handoff) begin
                    iters_left <= iters_left - ONE_I;
                end
            end
        end
    end

    for (genvar g = 0; g < GROUP_SIZE; g++) begin : g_lane
        mac_element #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_mac (
            .clk    (clk),
            .rst    (rst),
            .clear  (configure),
            .load   (accept_first),
            .add    (accept_more),
            .act    (act_data_in[g*DATA_WIDTH +: DATA_WIDTH]),
            .weight (w_sel),
            .acc    (data_out[g*ACC_WIDTH +: ACC_WIDTH])
        );
    end

    assign busy_out = (state != ST_IDLE);
    assign err_out  = err;

endmodule

// File: tb/tb_lane_mac.sv
// Bench for lane_mac: a 32-bit and a 16-bit accumulator instance share one stimulus stream,
// results are predicted by an arithmetic model and matched through expected queues.
module tb_lane_mac;

    localparam int GS   = 4;
    localparam int DW   = 8;
    localparam int AW   = 32;
    localparam int AW16 = 16;
    localparam int LI   = 16;
    localparam int LR   = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             configure = 1'b0;
    logic [LI-1:0]    num_iters = '0;
    logic [LR-1:0]    num_reads = '0;
    logic [GS*DW-1:0] act_data = '0;
    logic             act_valid = 1'b0;
    logic [DW-1:0]    weight = '0;
    logic             weight_valid = 1'b0;
    logic             avail_in = 1'b0;

    logic               act_avail, weight_avail, valid_out, busy, err;
    logic [GS*AW-1:0]   data_out;
    logic               act_avail16, weight_avail16, valid16, busy16, err16;
    logic [GS*AW16-1:0] data16;

    lane_mac #(.GROUP_SIZE(GS), .DATA_WIDTH(DW), .ACC_WIDTH(AW),
               .LOG_MAX_ITERS(LI), .LOG_MAX_READS_PER_ITER(LR)) dut (
        .clk(clk), .rst(rst), .configure(configure), .num_iters(num_iters),
        .num_reads_per_iter(num_reads), .act_data_in(act_data), .act_valid_in(act_valid),
        .act_avail_out(act_avail), .weight_in(weight), .weight_valid_in(weight_valid),
        .weight_avail_out(weight_avail), .data_out(data_out), .valid_out(valid_out),
        .avail_in(avail_in), .busy_out(busy), .err_out(err)
    );

    lane_mac #(.GROUP_SIZE(GS), .DATA_WIDTH(DW), .ACC_WIDTH(AW16),
               .LOG_MAX_ITERS(LI), .LOG_MAX_READS_PER_ITER(LR)) dut16 (
        .clk(clk), .rst(rst), .configure(configure), .num_iters(num_iters),
        .num_reads_per_iter(num_reads), .act_data_in(act_data), .act_valid_in(act_valid),
        .act_avail_out(act_avail16), .weight_in(weight), .weight_valid_in(weight_valid),
        .weight_avail_out(weight_avail16), .data_out(data16), .valid_out(valid16),
        .avail_in(avail_in), .busy_out(busy16), .err_out(err16)
    );

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    longint      m32[GS];
    longint      m16[GS];
    logic [DW-1:0] m_w;

    function automatic longint fold(longint v, int aw);
        longint span, hi, lo;
        span = longint'(1) <<< aw;
        hi   = (span >>> 1) - 1;
        lo   = -(span >>> 1);
`ifdef LANE_MAC_SATURATE_EN
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
`else
        v = v % span;
        if (v > hi) v = v - span;
        if (v < lo) v = v + span;
        return v;
`endif
    endfunction

    function automatic logic [127:0] exp_word(int aw);
        logic [127:0] r;
        longint       v;
        r = '0;
        for (int g = 0; g < GS; g++) begin
            if (aw == AW) begin
                v = m32[g];
                r[g*AW +: AW] = v[AW-1:0];
            end else begin
                v = m16[g];
                r[g*AW16 +: AW16] = v[AW16-1:0];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] pack4(int a0, int a1, int a2, int a3);
        return {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    endfunction

    // ---------------- scoreboard ----------------
    logic [127:0] exp_q[$];
    logic [127:0] exp16_q[$];
    int pulses   = 0;
    int pulses16 = 0;

    always @(negedge clk) begin
        if (valid_out) begin
            pulses++;
            if (exp_q.size() == 0) check("valid_unexpected", valid_out, 1'b0);
            else check("result32", data_out, exp_q.pop_front());
        end
        if (valid16) begin
            pulses16++;
            if (exp16_q.size() == 0) check("valid16_unexpected", valid16, 1'b0);
            else check("result16", data16, exp16_q.pop_front());
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_act_avail", act_avail, 1'b0);
        check("rst_weight_avail", weight_avail, 1'b0);
        check("rst_valid", valid_out, 1'b0);
        check("rst_data", data_out, '0);
        check("rst_data16", data16, '0);
        check("rst_busy16", {act_avail16, weight_avail16, valid16, busy16, err16}, '0);
    endtask

    task automatic cfg(input int it, input int rd);
        tick();
        num_iters = LI'(it);
        num_reads = LR'(rd);
        configure = 1'b1;
        tick();
        configure = 1'b0;
        @(negedge clk);
        if (it != 0 && rd != 0) begin
            check("cfg_weight_avail", weight_avail, 1'b1);
            check("cfg_err", err, 1'b0);
            check("cfg_err16", err16, 1'b0);
        end else begin
            check("cfg_bad_busy", busy, 1'b0);
            check("cfg_bad_err", err, 1'b1);
            check("cfg_bad_err16", err16, 1'b1);
        end
    endtask

    task automatic xfer(input bit first, input logic [DW-1:0] w, input logic [31:0] a);
        int n;
        int p;
        n = 0;
        @(negedge clk);
        while (!(first ? weight_avail : act_avail) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(first ? "xfer_weight_avail" : "xfer_act_avail", first ? weight_avail : act_avail, 1'b1);
        tick();
        act_data     = a;
        act_valid    = 1'b1;
        weight_valid = first;
        weight       = w;
        tick();
        act_valid    = 1'b0;
        weight_valid = 1'b0;
        if (first) m_w = w;
        for (int g = 0; g < GS; g++) begin
            p = int'($signed(a[g*DW +: DW])) * int'($signed(m_w));
            if (first) begin
                m32[g] = fold(longint'(p), AW);
                m16[g] = fold(longint'(p), AW16);
            end else begin
                m32[g] = fold(m32[g] + longint'(p), AW);
                m16[g] = fold(m16[g] + longint'(p), AW16);
            end
        end
    endtask

    task automatic flush(input int hold, input bit last);
        logic [127:0] e32;
        logic [127:0] e16;
        int n;
        int p0;
        e32 = exp_word(AW);
        e16 = exp_word(AW16);
        n   = 0;
        p0  = pulses;
        exp_q.push_back(e32);
        exp16_q.push_back(e16);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_data", data_out, e32);
            check("hold_act_avail", act_avail, 1'b0);
            check("hold_valid", valid_out, 1'b0);
        end
        tick();
        avail_in = 1'b1;
        while (pulses == p0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("pulse_count", pulses - p0, 1);
        tick();
        avail_in = 1'b0;
        @(negedge clk);
        check("busy_after_flush", busy, !last);
        check("busy16_after_flush", busy16, !last);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int p0;
        int iters, reads;
        logic [DW-1:0] w;
        logic [31:0]   a;

        do_reset();

        // three reads of {1,2,3,4} with weight 2
        cfg(1, 3);
        xfer(1, 8'd2, pack4(1, 2, 3, 4));
        xfer(0, 8'd0, pack4(1, 2, 3, 4));
        xfer(0, 8'd0, pack4(1, 2, 3, 4));
        @(negedge clk);
        check("dir_6_12_18_24", data_out, {32'd24, 32'd18, 32'd12, 32'd6});
        flush(5, 1);

        // two single-read iterations with weights -1 and 3
        cfg(2, 1);
        xfer(1, 8'hFF, pack4(5, 0, -5, 1));
        flush(0, 0);
        xfer(1, 8'd3, pack4(5, 0, -5, 1));
        @(negedge clk);
        check("dir_w3", data_out, {32'd3, 32'hFFFF_FFF1, 32'd0, 32'd15});
        flush(3, 1);

        // 127*127 three times overflows the 16-bit accumulators
        cfg(1, 3);
        xfer(1, 8'd127, pack4(127, 127, 127, 127));
        xfer(0, 8'd0, pack4(127, 127, 127, 127));
        xfer(0, 8'd0, pack4(127, 127, 127, 127));
        @(negedge clk);
        check("wide_lane0", data_out[31:0], 32'd48387);
`ifdef LANE_MAC_SATURATE_EN
        check("narrow_lane0", data16[15:0], 16'h7FFF);
`else
        check("narrow_lane0", data16[15:0], 16'hBD03);   // 48387 - 65536 = -17149
`endif
        flush(1, 1);

        // activation without weight in WAIT_W is flagged and not counted
        cfg(1, 2);
        tick();
        act_data  = pack4(9, 9, 9, 9);
        act_valid = 1'b1;
        tick();
        act_valid = 1'b0;
        @(negedge clk);
        check("err_no_weight", err, 1'b1);
        check("err_still_wait_w", weight_avail, 1'b1);
        xfer(1, 8'd5, pack4(-3, 7, 100, -128));
        xfer(0, 8'd0, pack4(1, -1, 20, 2));
        flush(2, 1);
        check("err_sticky", err, 1'b1);
        cfg(1, 0);
        cfg(0, 4);

        // reset in the middle of accumulation
        cfg(1, 4);
        xfer(1, 8'd7, pack4(1, 2, 3, 4));
        xfer(0, 8'd0, pack4(1, 2, 3, 4));
        p0 = pulses;
        do_reset();
        avail_in = 1'b1;
        repeat (4) @(negedge clk);
        tick();
        avail_in = 1'b0;
        check("rst_no_pulse", pulses, p0);

        // configure in the middle of accumulation restarts the job
        cfg(1, 4);
        xfer(1, 8'd7, pack4(1, 2, 3, 4));
        xfer(0, 8'd0, pack4(1, 2, 3, 4));
        p0 = pulses;
        cfg(1, 2);
        check("cfg_mid_no_pulse", pulses, p0);
        xfer(1, 8'hFD, pack4(11, -22, 33, -44));
        xfer(0, 8'd0, pack4(60, 70, -80, 90));
        flush(0, 1);

        // randomized jobs
        for (int j = 0; j < 10; j++) begin
            iters = $urandom_range(1, 3);
            reads = $urandom_range(1, 5);
            cfg(iters, reads);
            for (int it = 0; it < iters; it++) begin
                for (int r = 0; r < reads; r++) begin
                    w = 8'($urandom_range(0, 255));
                    a = $urandom();
                    xfer(r == 0, w, a);
                end
                flush($urandom_range(0, 3), it == iters - 1);
            end
        end

        check("queue_drained", exp_q.size() + exp16_q.size(), 0);
        check("pulse_match", pulses16, pulses);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
